// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand-fetch stage.
// Lane-class offsets describe the default 8-lane issue layout.
package operand_fetch_pkg;

  localparam int N_LANES = 8;
  localparam int N_WB    = 4;
  localparam int PREG_W  = 6;
  localparam int XLEN    = 64;

  localparam int ALU_LANE0  = 0;
  localparam int N_ALU      = 4;
  localparam int MEM_LANE0  = 4;
  localparam int N_MEM      = 2;
  localparam int BR_LANE0   = 6;
  localparam int MULT_LANE0 = 7;

  typedef logic              u1;
  typedef logic [XLEN-1:0]   word_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    u1     valid;
    word_t d1;
    word_t d2;
    preg_t psrc1;
    preg_t psrc2;
    u1     fwd_en1;
    u1     fwd_en2;
  } opfetch_lane_t;

endpackage

// File: rtl/operand_fetch_wb_bypass_sel.sv
// Single-operand writeback bypass: picks the lowest-index writeback port whose
// destination matches the tag, otherwise passes the fallback value through.
module wb_bypass_sel
  import operand_fetch_pkg::*;
#(
  parameter int NUM_WB = N_WB,
  parameter int TAG_W  = PREG_W,
  parameter int DATA_W = XLEN
) (
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [DATA_W-1:0]        i_fallback,
  input  logic [NUM_WB-1:0]        i_wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  i_wb_preg,
  input  logic [NUM_WB*DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_hit
);

  // Walk from the highest port down so the lowest matching port is applied last.
  always_comb begin
    o_data = i_fallback;
    o_hit  = 1'b0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (i_wb_valid[k] && (i_wb_preg[k*TAG_W +: TAG_W] == i_tag)) begin
        o_data = i_wb_data[k*DATA_W +: DATA_W];
        o_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage between issue and execute with same-cycle writeback bypass.
// Define OPFETCH_WB_REFRESH_EN to refresh held PRF operands from late writebacks.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int N_LANES = operand_fetch_pkg::N_LANES,
  parameter int N_WB    = operand_fetch_pkg::N_WB,
  parameter int PREG_W  = operand_fetch_pkg::PREG_W,
  parameter int XLEN    = operand_fetch_pkg::XLEN
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [N_LANES-1:0]        in_valid,
  output logic                      in_ready,
  input  logic [N_LANES-1:0]        fwd_en1,
  input  logic [N_LANES-1:0]        fwd_en2,
  input  logic [N_LANES*PREG_W-1:0] psrc1,
  input  logic [N_LANES*PREG_W-1:0] psrc2,
  output logic [N_LANES*PREG_W-1:0] prf_ra1,
  output logic [N_LANES*PREG_W-1:0] prf_ra2,
  input  logic [N_LANES*XLEN-1:0]   arf1,
  input  logic [N_LANES*XLEN-1:0]   arf2,
  input  logic [N_LANES*XLEN-1:0]   prf1,
  input  logic [N_LANES*XLEN-1:0]   prf2,
  input  logic [N_WB-1:0]           wb_valid,
  input  logic [N_WB*PREG_W-1:0]    wb_preg,
  input  logic [N_WB*XLEN-1:0]      wb_data,
  output logic [N_LANES-1:0]        out_valid,
  input  logic                      out_ready,
  output logic [N_LANES*XLEN-1:0]   out_d1,
  output logic [N_LANES*XLEN-1:0]   out_d2
);

  logic [N_LANES-1:0] r_valid;
  logic [XLEN-1:0]    r_d1 [N_LANES];
  logic [XLEN-1:0]    r_d2 [N_LANES];

  logic               w_in_ready;
  logic [XLEN-1:0]    w_sel1     [N_LANES];
  logic [XLEN-1:0]    w_sel2     [N_LANES];
  logic [XLEN-1:0]    w_cap_d1   [N_LANES];
  logic [XLEN-1:0]    w_cap_d2   [N_LANES];
  logic [N_LANES-1:0] w_cap_hit1;
  logic [N_LANES-1:0] w_cap_hit2;

`ifdef OPFETCH_WB_REFRESH_EN
  logic [PREG_W-1:0]  r_psrc1 [N_LANES];
  logic [PREG_W-1:0]  r_psrc2 [N_LANES];
  logic [N_LANES-1:0] r_fwd1;
  logic [N_LANES-1:0] r_fwd2;
  logic [XLEN-1:0]    w_ref_d1   [N_LANES];
  logic [XLEN-1:0]    w_ref_d2   [N_LANES];
  logic [N_LANES-1:0] w_ref_hit1;
  logic [N_LANES-1:0] w_ref_hit2;
`endif

  assign w_in_ready = ~|r_valid | out_ready;
  assign in_ready   = w_in_ready;
  assign out_valid  = r_valid;

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign prf_ra1[l*PREG_W +: PREG_W] = psrc1[l*PREG_W +: PREG_W];
    assign prf_ra2[l*PREG_W +: PREG_W] = psrc2[l*PREG_W +: PREG_W];
    assign out_d1[l*XLEN +: XLEN]      = r_d1[l];
    assign out_d2[l*XLEN +: XLEN]      = r_d2[l];

    // Writeback snoop is masked off for ARF-sourced operands so a hit always means bypass.
    wb_bypass_sel #(.NUM_WB(N_WB), .TAG_W(PREG_W), .DATA_W(XLEN)) u_cap1 (
      .i_tag      (psrc1[l*PREG_W +: PREG_W]),
      .i_fallback (prf1[l*XLEN +: XLEN]),
      .i_wb_valid (wb_valid & {N_WB{fwd_en1[l]}}),
      .i_wb_preg  (wb_preg),
      .i_wb_data  (wb_data),
      .o_data     (w_cap_d1[l]),
      .o_hit      (w_cap_hit1[l])
    );

    wb_bypass_sel #(.NUM_WB(N_WB), .TAG_W(PREG_W), .DATA_W(XLEN)) u_cap2 (
      .i_tag      (psrc2[l*PREG_W +: PREG_W]),
      .i_fallback (prf2[l*XLEN +: XLEN]),
      .i_wb_valid (wb_valid & {N_WB{fwd_en2[l]}}),
      .i_wb_preg  (wb_preg),
      .i_wb_data  (wb_data),
      .o_data     (w_cap_d2[l]),
      .o_hit      (w_cap_hit2[l])
    );

    assign w_sel1[l] = w_cap_hit1[l] ? w_cap_d1[l] : (fwd_en1[l] ? prf1[l*XLEN +: XLEN] : arf1[l*XLEN +: XLEN]);
    assign w_sel2[l] = w_cap_hit2[l] ? w_cap_d2[l] : (fwd_en2[l] ? prf2[l*XLEN +: XLEN] : arf2[l*XLEN +: XLEN]);

`ifdef OPFETCH_WB_REFRESH_EN
    wb_bypass_sel #(.NUM_WB(N_WB), .TAG_W(PREG_W), .DATA_W(XLEN)) u_ref1 (
      .i_tag      (r_psrc1[l]),
      .i_fallback (r_d1[l]),
      .i_wb_valid (wb_valid & {N_WB{r_valid[l] & r_fwd1[l]}}),
      .i_wb_preg  (wb_preg),
      .i_wb_data  (wb_data),
      .o_data     (w_ref_d1[l]),
      .o_hit      (w_ref_hit1[l])
    );

    wb_bypass_sel #(.NUM_WB(N_WB), .TAG_W(PREG_W), .DATA_W(XLEN)) u_ref2 (
      .i_tag      (r_psrc2[l]),
      .i_fallback (r_d2[l]),
      .i_wb_valid (wb_valid & {N_WB{r_valid[l] & r_fwd2[l]}}),
      .i_wb_preg  (wb_preg),
      .i_wb_data  (wb_data),
      .o_data     (w_ref_d2[l]),
      .o_hit      (w_ref_hit2[l])
    );
`endif
  end

  // Flush is applied last so it overrides capture and hold; data may still update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= '0;
      for (int l = 0; l < N_LANES; l++) begin
        r_d1[l] <= '0;
        r_d2[l] <= '0;
`ifdef OPFETCH_WB_REFRESH_EN
        r_psrc1[l] <= '0;
        r_psrc2[l] <= '0;
`endif
      end
`ifdef OPFETCH_WB_REFRESH_EN
      r_fwd1 <= '0;
      r_fwd2 <= '0;
`endif
    end else begin
      if (w_in_ready) begin
        r_valid <= in_valid;
        for (int l = 0; l < N_LANES; l++) begin
          r_d1[l] <= w_sel1[l];
          r_d2[l] <= w_sel2[l];
`ifdef OPFETCH_WB_REFRESH_EN
          r_psrc1[l] <= psrc1[l*PREG_W +: PREG_W];
          r_psrc2[l] <= psrc2[l*PREG_W +: PREG_W];
`endif
        end
`ifdef OPFETCH_WB_REFRESH_EN
        r_fwd1 <= fwd_en1;
        r_fwd2 <= fwd_en2;
`endif
      end
`ifdef OPFETCH_WB_REFRESH_EN
      else begin
        for (int l = 0; l < N_LANES; l++) begin
          if (w_ref_hit1[l]) r_d1[l] <= w_ref_d1[l];
          if (w_ref_hit2[l]) r_d2[l] <= w_ref_d2[l];
        end
      end
`endif
      if (flush) r_valid <= '0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of the stage.
module tb_operand_fetch;

  localparam int NL = 8;
  localparam int NW = 4;
  localparam int PW = 6;
  localparam int XW = 64;
`ifdef OPFETCH_WB_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn, flush, out_ready;
  logic [NL-1:0]    in_valid, fwd_en1, fwd_en2;
  logic [NL*PW-1:0] psrc1, psrc2;
  logic [NL*XW-1:0] arf1, arf2, prf1, prf2;
  logic [NW-1:0]    wb_valid;
  logic [NW*PW-1:0] wb_preg;
  logic [NW*XW-1:0] wb_data;
  wire  [NL*PW-1:0] prf_ra1, prf_ra2;
  wire  [NL-1:0]    out_valid;
  wire              in_ready;
  wire  [NL*XW-1:0] out_d1, out_d2;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the operand register should hold.
  logic [NL-1:0] m_valid;
  logic [XW-1:0] m_d1 [NL];
  logic [XW-1:0] m_d2 [NL];
  logic [PW-1:0] m_ps1 [NL];
  logic [PW-1:0] m_ps2 [NL];
  logic          m_f1 [NL];
  logic          m_f2 [NL];

  operand_fetch dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .fwd_en1(fwd_en1), .fwd_en2(fwd_en2), .psrc1(psrc1), .psrc2(psrc2),
    .prf_ra1(prf_ra1), .prf_ra2(prf_ra2), .arf1(arf1), .arf2(arf2),
    .prf1(prf1), .prf2(prf2), .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_d1(out_d1), .out_d2(out_d2)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [XW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [XW-1:0] wb_pick(input logic [PW-1:0] tag, input logic [XW-1:0] fb);
    for (int k = 0; k < NW; k++)
      if (wb_valid[k] && wb_preg[k*PW +: PW] == tag) return wb_data[k*XW +: XW];
    return fb;
  endfunction

  task automatic clear_inputs();
    flush = 0; out_ready = 0; in_valid = '0; fwd_en1 = '0; fwd_en2 = '0;
    psrc1 = '0; psrc2 = '0; arf1 = '0; arf2 = '0; prf1 = '0; prf2 = '0;
    wb_valid = '0; wb_preg = '0; wb_data = '0;
  endtask

  task automatic randomize_issue();
    in_valid = NL'($urandom); fwd_en1 = NL'($urandom); fwd_en2 = NL'($urandom);
    for (int l = 0; l < NL; l++) begin
      psrc1[l*PW +: PW] = PW'($urandom_range(0, 7));
      psrc2[l*PW +: PW] = PW'($urandom_range(0, 7));
      arf1[l*XW +: XW] = rnd64(); arf2[l*XW +: XW] = rnd64();
      prf1[l*XW +: XW] = rnd64(); prf2[l*XW +: XW] = rnd64();
    end
  endtask

  task automatic randomize_wb();
    wb_valid = NW'($urandom);
    for (int k = 0; k < NW; k++) begin
      wb_preg[k*PW +: PW] = PW'($urandom_range(0, 7));
      wb_data[k*XW +: XW] = rnd64();
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then step the DUT.
  task automatic model_tick();
    logic ir;
    if (!resetn) begin
      m_valid = '0;
      for (int l = 0; l < NL; l++) begin
        m_d1[l] = '0; m_d2[l] = '0; m_ps1[l] = '0; m_ps2[l] = '0; m_f1[l] = 0; m_f2[l] = 0;
      end
    end else begin
      ir = !(|m_valid) || out_ready;
      if (ir) begin
        for (int l = 0; l < NL; l++) begin
          m_valid[l] = in_valid[l];
          m_f1[l] = fwd_en1[l]; m_f2[l] = fwd_en2[l];
          m_ps1[l] = psrc1[l*PW +: PW]; m_ps2[l] = psrc2[l*PW +: PW];
          m_d1[l] = m_f1[l] ? wb_pick(m_ps1[l], prf1[l*XW +: XW]) : arf1[l*XW +: XW];
          m_d2[l] = m_f2[l] ? wb_pick(m_ps2[l], prf2[l*XW +: XW]) : arf2[l*XW +: XW];
        end
      end else if (REFRESH) begin
        for (int l = 0; l < NL; l++) begin
          if (m_valid[l] && m_f1[l]) m_d1[l] = wb_pick(m_ps1[l], m_d1[l]);
          if (m_valid[l] && m_f2[l]) m_d2[l] = wb_pick(m_ps2[l], m_d2[l]);
        end
      end
      if (flush) m_valid = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    resetn = 0; in_valid = '1; fwd_en1 = '1;
    randomize_wb();
    model_tick();
    model_tick();
    checks++;
    if (out_valid !== '0) begin errors++; $display("[TB] FAIL reset_valid: got %h want 00", out_valid); end
    checks++;
    if (out_d1 !== '0) begin errors++; $display("[TB] FAIL reset_d1: got %h want 0", out_d1); end
    checks++;
    if (out_d2 !== '0) begin errors++; $display("[TB] FAIL reset_d2: got %h want 0", out_d2); end
    @(negedge clk);
    resetn = 1; in_valid = '0; wb_valid = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    model_tick();
  endtask

  task automatic test_select();
    @(negedge clk);
    clear_inputs();
    out_ready = 1; in_valid[0] = 1; fwd_en1[0] = 0; psrc1[PW-1:0] = 6'd13;
    arf1[XW-1:0] = 64'h11; prf1[XW-1:0] = 64'h22;
    #1;
    checks++;
    if (prf_ra1[PW-1:0] !== 6'd13) begin errors++; $display("[TB] FAIL prf_ra1: got %0d want 13", prf_ra1[PW-1:0]); end
    model_tick();
    checks++;
    if (out_d1[XW-1:0] !== 64'h11) begin errors++; $display("[TB] FAIL sel_arf: got %h want 11", out_d1[XW-1:0]); end
    checks++;
    if (out_valid !== 8'h01) begin errors++; $display("[TB] FAIL sel_valid: got %h want 01", out_valid); end
    @(negedge clk);
    fwd_en1[0] = 1;
    model_tick();
    checks++;
    if (out_d1[XW-1:0] !== 64'h22) begin errors++; $display("[TB] FAIL sel_prf: got %h want 22", out_d1[XW-1:0]); end
  endtask

  task automatic test_wb_priority();
    @(negedge clk);
    clear_inputs();
    out_ready = 1; in_valid[3] = 1; fwd_en2[3] = 1;
    psrc2[3*PW +: PW] = 6'd5; prf2[3*XW +: XW] = 64'hAA;
    wb_valid = 4'b0110;
    wb_preg[1*PW +: PW] = 6'd5; wb_preg[2*PW +: PW] = 6'd5;
    wb_data[1*XW +: XW] = 64'hB1; wb_data[2*XW +: XW] = 64'hB2;
    model_tick();
    checks++;
    if (out_d2[3*XW +: XW] !== 64'hB1) begin errors++; $display("[TB] FAIL wb_priority: got %h want b1", out_d2[3*XW +: XW]); end
  endtask

  task automatic test_stall_refresh();
    logic [XW-1:0] exp1;
    @(negedge clk);
    clear_inputs();
    out_ready = 1; in_valid[1] = 1; fwd_en1[1] = 1; psrc1[1*PW +: PW] = 6'd9;
    prf1[1*XW +: XW] = 64'h55; fwd_en2[1] = 0; arf2[1*XW +: XW] = 64'h66;
    model_tick();
    checks++;
    if (out_d1[1*XW +: XW] !== 64'h55) begin errors++; $display("[TB] FAIL stall_capture: got %h want 55", out_d1[1*XW +: XW]); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      randomize_issue();
      in_valid = '1; out_ready = 0; wb_valid = '0;
      if (c == 2) begin
        wb_valid = 4'b0001; wb_preg[PW-1:0] = 6'd9; wb_data[XW-1:0] = 64'h77;
      end
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
      model_tick();
      checks++;
      if (out_valid !== 8'h02) begin errors++; $display("[TB] FAIL stall_valid c%0d: got %h want 02", c, out_valid); end
    end
    exp1 = REFRESH ? 64'h77 : 64'h55;
    checks++;
    if (out_d1[1*XW +: XW] !== exp1) begin errors++; $display("[TB] FAIL stall_refresh: got %h want %h", out_d1[1*XW +: XW], exp1); end
    checks++;
    if (out_d2[1*XW +: XW] !== 64'h66) begin errors++; $display("[TB] FAIL stall_arf_hold: got %h want 66", out_d2[1*XW +: XW]); end
    @(negedge clk);
    clear_inputs();
    out_ready = 1;
    model_tick();
  endtask

  task automatic test_flush();
    @(negedge clk);
    clear_inputs();
    randomize_issue();
    out_ready = 1; in_valid = '1;
    model_tick();
    checks++;
    if (out_valid !== 8'hFF) begin errors++; $display("[TB] FAIL flush_fill: got %h want ff", out_valid); end
    @(negedge clk);
    out_ready = 0; in_valid = '0;
    model_tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_stalled: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1;
    model_tick();
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("[TB] FAIL flush_valid: got %h want 00", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    flush = 0; out_ready = 1; in_valid = '1;
    model_tick();
    @(negedge clk);
    out_ready = 0; resetn = 0;
    model_tick();
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("[TB] FAIL stall_reset: got %h want 00", out_valid); end
    @(negedge clk);
    resetn = 1; in_valid = '0;
    model_tick();
  endtask

  task automatic test_back_to_back();
    logic [NL*XW-1:0] q1 [$];
    logic [NL*XW-1:0] q2 [$];
    logic [NL*XW-1:0] e1, e2;
    for (int g = 0; g <= 16; g++) begin
      @(negedge clk);
      clear_inputs();
      out_ready = 1;
      if (g < 16) begin
        randomize_issue();
        randomize_wb();
        in_valid = '1;
        for (int l = 0; l < NL; l++) begin
          e1[l*XW +: XW] = fwd_en1[l] ? wb_pick(psrc1[l*PW +: PW], prf1[l*XW +: XW]) : arf1[l*XW +: XW];
          e2[l*XW +: XW] = fwd_en2[l] ? wb_pick(psrc2[l*PW +: PW], prf2[l*XW +: XW]) : arf2[l*XW +: XW];
        end
        q1.push_back(e1);
        q2.push_back(e2);
      end
      model_tick();
      if (g < 16) begin
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        checks++;
        if (out_valid !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_valid g%0d: got %h want ff", g, out_valid); end
        checks++;
        if (out_d1 !== e1) begin errors++; $display("[TB] FAIL b2b_d1 g%0d: got %h want %h", g, out_d1[XW-1:0], e1[XW-1:0]); end
        checks++;
        if (out_d2 !== e2) begin errors++; $display("[TB] FAIL b2b_d2 g%0d: got %h want %h", g, out_d2[XW-1:0], e2[XW-1:0]); end
      end
    end
    checks++;
    if (out_valid !== 8'h00) begin errors++; $display("[TB] FAIL b2b_drain: got %h want 00", out_valid); end
  endtask

  task automatic test_random();
    logic exp_ir;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      randomize_issue();
      randomize_wb();
      out_ready = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 15) == 0);
      resetn    = ($urandom_range(0, 63) != 0);
      #1;
      exp_ir = !(|m_valid) || out_ready;
      checks++;
      if (in_ready !== exp_ir) begin errors++; $display("[TB] FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_ir); end
      checks++;
      if (prf_ra1 !== psrc1 || prf_ra2 !== psrc2) begin errors++; $display("[TB] FAIL rnd_prf_ra c%0d: got %h want %h", c, prf_ra1, psrc1); end
      model_tick();
      checks++;
      if (out_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %h want %h", c, out_valid, m_valid); end
      for (int l = 0; l < NL; l++) begin
        if (m_valid[l]) begin
          checks++;
          if (out_d1[l*XW +: XW] !== m_d1[l]) begin errors++; $display("[TB] FAIL rnd_d1 c%0d lane%0d: got %h want %h", c, l, out_d1[l*XW +: XW], m_d1[l]); end
          checks++;
          if (out_d2[l*XW +: XW] !== m_d2[l]) begin errors++; $display("[TB] FAIL rnd_d2 c%0d lane%0d: got %h want %h", c, l, out_d2[l*XW +: XW], m_d2[l]); end
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    test_reset();
    test_select();
    test_wb_priority();
    test_stall_refresh();
    test_flush();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
